// File: rtl/game_controller_pkg.sv
// game_controller_pkg: shared state encoding and widths for the number-match game.
package game_controller_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, PLAY, CHECK, OVER} state_e;
    localparam int LEVEL_W = 2;
    localparam int DIGIT_W = 4;
    localparam int SCORE_MAX_DEF = 99;
endpackage

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: two-digit BCD up/down counter saturating at 00 and MAX.
module bcd_score_counter
    import game_controller_pkg::*;
#(
    parameter int MAX = SCORE_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               inc_i,
    input  logic               dec_i,
    output logic [DIGIT_W-1:0] tens_o,
    output logic [DIGIT_W-1:0] ones_o
);
    localparam logic [DIGIT_W-1:0] MAX_T = DIGIT_W'(MAX / 10);
    localparam logic [DIGIT_W-1:0] MAX_O = DIGIT_W'(MAX % 10);
    logic [DIGIT_W-1:0] tens_q, tens_d, ones_q, ones_d;
    logic at_max, at_zero;
    assign at_max  = tens_q == MAX_T && ones_q == MAX_O;
    assign at_zero = tens_q == '0 && ones_q == '0;
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr_i) begin
            tens_d = '0;
            ones_d = '0;
        end else if (inc_i && !at_max) begin
            ones_d = ones_q == DIGIT_W'(9) ? '0 : ones_q + DIGIT_W'(1);
            tens_d = ones_q == DIGIT_W'(9) ? tens_q + DIGIT_W'(1) : tens_q;
        end else if (dec_i && !at_zero) begin
            ones_d = ones_q == '0 ? DIGIT_W'(9) : ones_q - DIGIT_W'(1);
            tens_d = ones_q == '0 ? tens_q - DIGIT_W'(1) : tens_q;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end
    assign tens_o = tens_q;
    assign ones_o = ones_q;
endmodule

// File: rtl/game_controller.sv
// game_controller: one round of the number-match game driving the countdown timer.
// Define GAME_PENALTY_EN to make a mismatch cost one point and clear the match streak.
module game_controller
    import game_controller_pkg::*;
#(
    parameter int LEVEL_STEP = 4,
    parameter int MAX_LEVEL  = 3,
    parameter int SCORE_MAX  = SCORE_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               logged_in,
    input  logic               p_Bout,
    input  logic [3:0]         userInput,
    input  logic [3:0]         rngValue,
    input  logic               timeout,
    output logic               timerReconfig,
    output logic               timerEnable,
    output logic [LEVEL_W-1:0] gameLevel,
    output logic               rngNext,
    output logic [DIGIT_W-1:0] scoreTens,
    output logic [DIGIT_W-1:0] scoreOnes,
    output logic               gameOver
);
    localparam int CNT_W = $clog2(LEVEL_STEP) + 1;
    state_e state_q, state_d;
    logic [3:0]         guess_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [LEVEL_W-1:0] level_q;
    logic               rng_next_q;
    logic               start, hit, miss, level_up, dec;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (logged_in && p_Bout) state_d = LOAD;
            LOAD:    state_d = PLAY;
            PLAY:    state_d = timeout ? OVER : (p_Bout ? CHECK : PLAY);
            CHECK:   state_d = guess_q == rngValue ? LOAD : PLAY;
            OVER:    if (p_Bout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Logging out aborts the round from anywhere, overriding the game flow.
        if (state_q != IDLE && !logged_in) state_d = IDLE;
    end
    assign start    = state_q == IDLE && state_d == LOAD;
    assign hit      = state_q == CHECK && state_d == LOAD;
    assign miss     = state_q == CHECK && state_d == PLAY;
    assign level_up = hit && cnt_q == CNT_W'(LEVEL_STEP - 1);
`ifdef GAME_PENALTY_EN
    assign dec = miss;
`else
    assign dec = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            guess_q    <= '0;
            cnt_q      <= '0;
            level_q    <= '0;
            rng_next_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rng_next_q <= state_d == LOAD || miss;
            if (state_q == PLAY && p_Bout) guess_q <= userInput;
            if (start) begin
                cnt_q   <= '0;
                level_q <= '0;
            end else if (level_up) begin
                cnt_q <= '0;
                if (level_q < LEVEL_W'(MAX_LEVEL)) level_q <= level_q + LEVEL_W'(1);
            end else if (hit) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (dec) begin
                cnt_q <= '0;
            end
        end
    end
    bcd_score_counter #(.MAX(SCORE_MAX)) u_score (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start),
        .inc_i  (hit),
        .dec_i  (dec),
        .tens_o (scoreTens),
        .ones_o (scoreOnes)
    );
    assign timerReconfig = state_q == LOAD;
    assign timerEnable   = state_q == PLAY || state_q == CHECK;
    assign gameOver      = state_q == OVER;
    assign gameLevel     = level_q;
    assign rngNext       = rng_next_q;
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed stimulus checked each cycle against an integer-score game model.
module tb_game_controller;
    logic       clk, rst, logged_in, p_Bout, timeout;
    logic [3:0] userInput, rngValue;
    logic       timerReconfig, timerEnable, rngNext, gameOver;
    logic [1:0] gameLevel;
    logic [3:0] scoreTens, scoreOnes;
    int tests, fails;
    bit chk_en;
    int m_ph, m_sc, m_lv, m_hits;
    logic [3:0] m_guess;
    bit m_rng;

    game_controller dut (
        .clk(clk), .rst(rst), .logged_in(logged_in), .p_Bout(p_Bout),
        .userInput(userInput), .rngValue(rngValue), .timeout(timeout),
        .timerReconfig(timerReconfig), .timerEnable(timerEnable),
        .gameLevel(gameLevel), .rngNext(rngNext), .scoreTens(scoreTens),
        .scoreOnes(scoreOnes), .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Phases: 0 idle, 1 load, 2 play, 3 check, 4 over; score kept as a plain integer.
    always @(posedge clk) begin
        m_rng <= 1'b0;
        if (!rst) begin
            m_ph <= 0; m_sc <= 0; m_lv <= 0; m_hits <= 0;
        end else if (m_ph != 0 && !logged_in) begin
            m_ph <= 0;
        end else begin
            case (m_ph)
                0: if (logged_in && p_Bout) begin
                    m_ph <= 1; m_sc <= 0; m_lv <= 0; m_hits <= 0; m_rng <= 1'b1;
                end
                1: m_ph <= 2;
                2: if (timeout) m_ph <= 4;
                   else if (p_Bout) begin m_ph <= 3; m_guess <= userInput; end
                3: if (m_guess == rngValue) begin
                    m_ph <= 1; m_rng <= 1'b1;
                    m_sc <= (m_sc < 99) ? m_sc + 1 : 99;
                    if (m_hits + 1 == 4) begin
                        m_hits <= 0;
                        m_lv <= (m_lv < 3) ? m_lv + 1 : 3;
                    end else m_hits <= m_hits + 1;
                end else begin
                    m_ph <= 2; m_rng <= 1'b1;
`ifdef GAME_PENALTY_EN
                    m_sc <= (m_sc > 0) ? m_sc - 1 : 0;
                    m_hits <= 0;
`endif
                end
                4: if (p_Bout) m_ph <= 0;
                default: m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_timerReconfig", 8'(timerReconfig), 8'(m_ph == 1));
            chk("m_timerEnable", 8'(timerEnable), 8'(m_ph == 2 || m_ph == 3));
            chk("m_gameOver", 8'(gameOver), 8'(m_ph == 4));
            chk("m_rngNext", 8'(rngNext), 8'(m_rng));
            chk("m_gameLevel", 8'(gameLevel), 8'(m_lv));
            chk("m_scoreTens", 8'(scoreTens), 8'(m_sc / 10));
            chk("m_scoreOnes", 8'(scoreOnes), 8'(m_sc % 10));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press;
        p_Bout = 1'b1;
        @(negedge clk);
        p_Bout = 1'b0;
    endtask

    initial begin
        clk = 0; rst = 0; logged_in = 0; p_Bout = 0; timeout = 0;
        userInput = 0; rngValue = 0; tests = 0; fails = 0; chk_en = 0;
        tick(2);
        chk_en = 1;
        chk("rst_level", 8'(gameLevel), 8'd0);
        chk("rst_score", 8'({scoreTens, scoreOnes}), 8'h00);
        chk("rst_enable", 8'(timerEnable), 8'd0);
        rst = 1; logged_in = 1;
        press;
        chk("start_reconfig", 8'(timerReconfig), 8'd1);
        chk("start_rngnext", 8'(rngNext), 8'd1);
        chk("start_enable", 8'(timerEnable), 8'd0);
        tick(1);
        chk("play_enable", 8'(timerEnable), 8'd1);
        chk("play_reconfig", 8'(timerReconfig), 8'd0);
        chk("play_score", 8'({scoreTens, scoreOnes}), 8'h00);
        rngValue = 7; userInput = 7;
        repeat (4) begin press; tick(3); end
        chk("match4_score", 8'({scoreTens, scoreOnes}), 8'h04);
        chk("match4_level", 8'(gameLevel), 8'd1);
        rngValue = 3; userInput = 5;
        press;
        tick(1);
        chk("miss_rngnext", 8'(rngNext), 8'd1);
        chk("miss_reconfig", 8'(timerReconfig), 8'd0);
`ifdef GAME_PENALTY_EN
        chk("miss_score", 8'({scoreTens, scoreOnes}), 8'h03);
`else
        chk("miss_score", 8'({scoreTens, scoreOnes}), 8'h04);
`endif
        timeout = 1;
        tick(1);
        timeout = 0;
        chk("to_gameover", 8'(gameOver), 8'd1);
        chk("to_enable", 8'(timerEnable), 8'd0);
        chk("to_level", 8'(gameLevel), 8'd1);
        press;
        press;
        tick(1);
        timeout = 1; p_Bout = 1;
        tick(1);
        timeout = 0; p_Bout = 0;
        chk("tocoinc_gameover", 8'(gameOver), 8'd1);
        chk("tocoinc_score", 8'({scoreTens, scoreOnes}), 8'h00);
        press;
        press;
        tick(1);
        rngValue = 7; userInput = 7;
        repeat (101) begin press; tick(2); end
        chk("sat_score", 8'({scoreTens, scoreOnes}), 8'h99);
        chk("sat_level", 8'(gameLevel), 8'd3);
        logged_in = 0;
        tick(1);
        chk("logout_enable", 8'(timerEnable), 8'd0);
        chk("logout_score", 8'({scoreTens, scoreOnes}), 8'h99);
        logged_in = 1;
        press;
        tick(1);
        press;
        rst = 0;
        tick(1);
        rst = 1;
        chk("abort_level", 8'(gameLevel), 8'd0);
        chk("abort_score", 8'({scoreTens, scoreOnes}), 8'h00);
        chk("abort_outs", 8'({timerReconfig, timerEnable, rngNext, gameOver}), 8'd0);
        press;
        tick(1);
        rngValue = 3; userInput = 5;
        press;
        tick(1);
        chk("zero_miss_score", 8'({scoreTens, scoreOnes}), 8'h00);
        chk("zero_miss_rngnext", 8'(rngNext), 8'd1);
        tick(2);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Initiator side of the countdown-timer interface. Drives reconfig/enable/level into the two-digit timer, consumes its timeout, and runs one round of the number-match game.
- The player matches the random digit shown on the RNG display by setting userInput and pressing the player button. Correct matches score points, and the level rises as the score grows.
- Sits between the authentication block (which supplies logged_in), the sequencer (which supplies rngValue and consumes rngNext), and the timer and score displays.

Parameters:
- LEVEL_STEP, 4: number of correct matches required to advance one game level.
- MAX_LEVEL, 3: highest gameLevel value; the level saturates here.
- SCORE_MAX, 99: BCD score ceiling; the score saturates here.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset.
- logged_in  input  1  user authenticated; level-sensitive.
- p_Bout  input  1  shaped player button, one-cycle pulse.
- userInput  input  4  player's guess, binary 0-15.
- rngValue  input  4  current random target from the sequencer.
- timeout  input  1  from the timer; high while the countdown is at 00.
- timerReconfig  output  1  one-cycle pulse; the timer reloads its start value from gameLevel.
- timerEnable  output  1  high while the timer should count.
- gameLevel  output  2  current level, 0..MAX_LEVEL.
- rngNext  output  1  one-cycle pulse asking the sequencer to advance rngValue.
- scoreTens  output  4  BCD tens digit of the score.
- scoreOnes  output  4  BCD ones digit of the score.
- gameOver  output  1  high in the OVER state.

Behaviour:
- Reset: if rst==0 at a clk edge, the following are set.
  - State = IDLE.
  - All outputs = 0: gameLevel=0, score=00, timerReconfig=0, timerEnable=0, rngNext=0, gameOver=0.
  - Internal match counter = 0.
- Reset mid-game aborts immediately; there is no partial-round retention.
- States: IDLE, LOAD, PLAY, CHECK, OVER.
- IDLE:
  - Outputs quiescent.
  - If logged_in==1 and p_Bout==1: go to LOAD, clear score, level, and match counter.
- LOAD (one cycle):
  - Assert timerReconfig and rngNext for this cycle only; timerEnable=0.
  - Next state is PLAY.
- PLAY:
  - timerEnable=1.
  - On p_Bout: register userInput and go to CHECK. timerEnable stays 1, so the timer keeps running.
  - On timeout==1 with no p_Bout: go to OVER.
  - If timeout and p_Bout arrive in the same cycle, timeout wins and the press is ignored.
- CHECK (one cycle):
  - Compare the registered guess with rngValue as sampled in this cycle.
  - Match:
    - Score += 1 in BCD. Ones 9->0 with tens +1; the score saturates at SCORE_MAX and holds 99.
    - Match counter += 1. When it reaches LEVEL_STEP, it clears and gameLevel increments (saturating at MAX_LEVEL).
    - Go to LOAD, which reloads the timer with the new level and fetches a new target.
  - Mismatch: no score change (see the optional feature). Assert rngNext, go to PLAY; the timer is not reloaded.
- OVER:
  - gameOver=1, timerEnable=0; score and level are held for display.
  - p_Bout returns to IDLE, and the score clears on the next start.
- logged_in falling in any state other than IDLE: go to IDLE on the next edge; timerEnable drops the same cycle the state changes.
- timerReconfig and rngNext are never high for more than one consecutive cycle.
- All outputs are registered; the latency from p_Bout to the score update is 2 clk edges (PLAY->CHECK->update).

Optional Feature:
- Macro: GAME_PENALTY_EN.
- Defined: a mismatch in CHECK decrements the score by 1 in BCD (tens borrow on 0->9). The score saturates at 00, and the match counter clears to 0.
- Undefined: a mismatch leaves the score and match counter unchanged.
- Level never decreases in either build.

Decomposition:
- Shared package:
  - state enum (IDLE, LOAD, PLAY, CHECK, OVER) with a 3-bit encoding;
  - level width constant (2);
  - BCD digit width (4);
  - SCORE_MAX default.
- One natural sub-module: bcd_score_counter, a two-digit BCD up/down counter with inc, dec, clr, and saturation at 00/99. It is reusable by the display path.

Test Plan:
- Start: rst=0 for 2 cycles, then logged_in=1 and a p_Bout pulse. Required: one-cycle timerReconfig and rngNext the cycle after, then timerEnable=1, score=00, gameLevel=0.
- Matches: rngValue=7, userInput=7, 4 p_Bout pulses spaced over 5+ cycles. Required: score counts 01..04, gameLevel 0->1 after the 4th match, plus an extra timerReconfig for each match.
- Mismatch: rngValue=3, userInput=5, one pulse. Required: score unchanged, rngNext pulse, no timerReconfig. With GAME_PENALTY_EN, score 04->03; with score=00, it stays 00.
- Timeout: hold timeout=1 in PLAY, both alone and coincident with p_Bout. Required: OVER next cycle, gameOver=1, timerEnable=0, score held.
- Saturation: preload 98 via matches, then 3 more matches. Required: 99 is held; with the level already at 3, gameLevel stays 3.
- Abort: drop logged_in during PLAY, then separately pulse rst=0 during CHECK. Required: IDLE with timerEnable=0 on the next edge; after reset, all outputs are 0.
